// File: rtl/game_score_keeper.sv
// Score/lives keeper for a tile-matching game: BCD score, thermometer lives, 4-state game FSM.
// Outputs decode registered state only, so an input pulse shows up one clock later.
module game_score_keeper #(
  parameter int MAX_SCORE = 32,
  parameter int LIVES     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       userquit,
  input  logic       match_pulse,
  input  logic       miss_pulse,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER_WIN, OVER_LOSE} state_t;

  localparam logic [3:0] MAX_TENS   = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES   = 4'(MAX_SCORE % 10);
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] lives_q, lives_d;
  logic       start_q, quit_q;
  logic       start_evt, quit_evt;
  logic       at_max;
  logic [3:0] ones_inc, tens_inc;

  assign start_evt = start & ~start_q;
  assign quit_evt  = userquit & ~quit_q;
  assign at_max    = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

  always_comb begin
    ones_inc = ones_q + 4'd1;
    tens_inc = tens_q;
    if (ones_q == 4'd9) begin
      ones_inc = 4'd0;
      tens_inc = tens_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    lives_d = lives_q;
    case (state_q)
      PLAY: begin
        if (match_pulse && !at_max) begin
          ones_d = ones_inc;
          tens_d = tens_inc;
        end
        if (miss_pulse && (lives_q != 4'd0)) begin
          lives_d = lives_q - 4'd1;
        end
        // A win reached by this cycle's match beats a simultaneous loss or quit.
        if ((tens_d == MAX_TENS) && (ones_d == MAX_ONES)) begin
          state_d = OVER_WIN;
        end else if ((lives_d == 4'd0) || quit_evt) begin
          state_d = OVER_LOSE;
        end
      end
      IDLE, OVER_WIN, OVER_LOSE: begin
        if (start_evt) begin
          state_d = PLAY;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          lives_d = LIVES_INIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      lives_q <= LIVES_INIT;
      start_q <= 1'b0;
      quit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      lives_q <= lives_d;
      start_q <= start;
      quit_q  <= userquit;
    end
  end

  always_comb begin
    ingameOn = (state_q == PLAY);
    gameOver = (state_q == OVER_WIN) || (state_q == OVER_LOSE);
    hex4hldr = ones_q;
    hex5hldr = tens_q;
    case (state_q)
      IDLE:      hex0hldr = 4'hF;
      PLAY:      hex0hldr = 4'h1;
      OVER_WIN:  hex0hldr = 4'hA;
      OVER_LOSE: hex0hldr = 4'hE;
      default:   hex0hldr = 4'hF;
    endcase
    for (int i = 0; i < 10; i++) begin
      ledrhldr[i] = (lives_q > 4'(i));
    end
  end

endmodule

// File: tb/tb_game_score_keeper.sv
// Randomized bench for game_score_keeper against an integer-level game model.
module tb_game_score_keeper;

  localparam int MAX_SCORE = 32;
  localparam int LIVES     = 10;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_WIN  = 2;
  localparam int M_LOSE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, userquit, match_pulse, miss_pulse;
  logic       ingameOn, gameOver;
  logic [3:0] hex0hldr, hex4hldr, hex5hldr;
  logic [9:0] ledrhldr;

  int vectors = 0;
  int miscompares = 0;

  int m_state, m_score, m_lives;
  logic m_prev_start, m_prev_quit;

  always #5 clk = ~clk;

  game_score_keeper #(.MAX_SCORE(MAX_SCORE), .LIVES(LIVES)) dut (
    .clk(clk), .reset(reset), .start(start), .userquit(userquit),
    .match_pulse(match_pulse), .miss_pulse(miss_pulse),
    .ingameOn(ingameOn), .gameOver(gameOver), .hex0hldr(hex0hldr),
    .hex4hldr(hex4hldr), .hex5hldr(hex5hldr), .ledrhldr(ledrhldr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_score = 0;
    m_lives = LIVES;
    m_prev_start = 1'b0;
    m_prev_quit  = 1'b0;
  endtask

  task automatic model_update(input logic s, input logic q, input logic m, input logic x);
    bit s_evt, q_evt;
    s_evt = s && !m_prev_start;
    q_evt = q && !m_prev_quit;
    m_prev_start = s;
    m_prev_quit  = q;
    if (m_state == M_PLAY) begin
      if (m && m_score < MAX_SCORE) m_score++;
      if (x && m_lives > 0) m_lives--;
      if (m_score == MAX_SCORE) m_state = M_WIN;
      else if (m_lives == 0 || q_evt) m_state = M_LOSE;
    end else if (s_evt) begin
      m_state = M_PLAY;
      m_score = 0;
      m_lives = LIVES;
    end
  endtask

  task automatic compare_all();
    logic [3:0] code;
    logic [9:0] therm;
    case (m_state)
      M_PLAY:  code = 4'h1;
      M_WIN:   code = 4'hA;
      M_LOSE:  code = 4'hE;
      default: code = 4'hF;
    endcase
    therm = 10'((1 << m_lives) - 1);
    check("ingameOn", 32'(ingameOn), 32'(m_state == M_PLAY));
    check("gameOver", 32'(gameOver), 32'(m_state == M_WIN || m_state == M_LOSE));
    check("hex0", 32'(hex0hldr), 32'(code));
    check("hex4", 32'(hex4hldr), 32'(m_score % 10));
    check("hex5", 32'(hex5hldr), 32'(m_score / 10));
    check("ledr", 32'(ledrhldr), 32'(therm));
  endtask

  task automatic step(input logic s, input logic q, input logic m, input logic x);
    @(negedge clk);
    start = s; userquit = q; match_pulse = m; miss_pulse = x;
    @(posedge clk);
    model_update(s, q, m, x);
    #1 compare_all();
  endtask

  // Reset lands between edges; outputs must respond before any clock.
  task automatic async_reset_check();
    #1 reset = 1'b1;
    start = 1'b0; userquit = 1'b0; match_pulse = 1'b0; miss_pulse = 1'b0;
    model_reset();
    #1 compare_all();
    check("rst_ledr_const", 32'(ledrhldr), 32'h3FF);
    @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    logic s_lvl, q_lvl;
    reset = 1'b1;
    start = 1'b0; userquit = 1'b0; match_pulse = 1'b0; miss_pulse = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    check("rst_hex0_const", 32'(hex0hldr), 32'hF);
    @(negedge clk) reset = 1'b0;

    // Tens carry after nine matches
    step(1, 0, 0, 0);
    repeat (9) step(0, 0, 1, 0);
    check("carry_pre_hex4", 32'(hex4hldr), 32'd9);
    step(0, 0, 1, 0);
    check("carry_hex5", 32'(hex5hldr), 32'd1);
    check("carry_hex4", 32'(hex4hldr), 32'd0);

    // Win at MAX_SCORE, score then frozen
    repeat (22) step(0, 0, 1, 0);
    check("win_hex0", 32'(hex0hldr), 32'hA);
    step(0, 0, 1, 0);
    check("win_frozen_hex4", 32'(hex4hldr), 32'd2);

    // Run out of lives
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1);
    check("lose_hex0", 32'(hex0hldr), 32'hE);
    check("lose_ledr", 32'(ledrhldr), 32'h000);

    // Score 31 / lives 1, match+miss together wins
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (9) step(1, 0, 0, 1);
    repeat (31) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("both_hex0", 32'(hex0hldr), 32'hA);
    check("both_ledr", 32'(ledrhldr), 32'h000);

    // Quit at score 05, restart while quit still held
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    check("quit_hex0", 32'(hex0hldr), 32'hE);
    step(0, 1, 1, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("restart_ledr", 32'(ledrhldr), 32'h3FF);

    // Held start gives one game; mid-game async reset
    async_reset_check();
    repeat (5) step(1, 0, 1, 0);
    step(0, 0, 1, 1);
    async_reset_check();

    // Random play
    s_lvl = 1'b0;
    q_lvl = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 8) s_lvl = ~s_lvl;
      if ($urandom_range(0, 99) < 3) q_lvl = ~q_lvl;
      step(s_lvl, q_lvl, 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 12));
      if ($urandom_range(0, 499) == 0) begin
        async_reset_check();
        s_lvl = 1'b0;
        q_lvl = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_score_keeper.md
GAME_SCORE_KEEPER -- requirements
Module: game_score_keeper

Interface
REQ-001 The block SHALL have parameter MAX_SCORE, default 32, meaning the winning score (legal range 1..99).
REQ-002 The block SHALL have parameter LIVES, default 10, meaning the miss budget per game (legal range 1..10).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high (ports named clk and reset).
REQ-004 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: level from the start key; acted on at its rising edge only.
REQ-007 Port userquit, input, 1: level from the quit switch; acted on at its rising edge only.
REQ-008 Port match_pulse, input, 1: single-cycle pulse, one tile pair matched.
REQ-009 Port miss_pulse, input, 1: single-cycle pulse, one pair mismatched.
REQ-010 Port ingameOn, output, 1: high while in PLAY.
REQ-011 Port gameOver, output, 1: high while in OVER_WIN or OVER_LOSE.
REQ-012 Port hex0hldr, output, 4: state code for the HEX0 digit.
REQ-013 Port hex4hldr, output, 4: score ones digit, BCD 0..9.
REQ-014 Port hex5hldr, output, 4: score tens digit, BCD 0..9.
REQ-015 Port ledrhldr, output, 10: remaining lives as a thermometer, bit i high iff lives > i.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, OVER_WIN, OVER_LOSE; hex0hldr SHALL be 4'hF, 4'h1, 4'hA, 4'hE respectively.
REQ-017 start and userquit SHALL each be registered once and edge-detected; an event is a cycle where current = 1 and previous = 0.
REQ-018 IDLE -> PLAY on a start edge; on that transition score SHALL clear to 00 and lives SHALL load LIVES.
REQ-019 In PLAY, score SHALL be held as two BCD digits; match_pulse SHALL increment by one with ones-digit carry 9 -> 0 into tens.
REQ-020 In PLAY, miss_pulse SHALL decrement lives by one, saturating at 0.
REQ-021 When match_pulse and miss_pulse are high in the same cycle, both SHALL be applied in that cycle.
REQ-022 PLAY -> OVER_WIN in the cycle the updated score equals MAX_SCORE; this has priority over every other exit.
REQ-023 PLAY -> OVER_LOSE in the cycle the updated lives equals 0, unless REQ-022 applies.
REQ-024 PLAY -> OVER_LOSE on a userquit edge, unless REQ-022 applies; pulses in that cycle SHALL still update score and lives.
REQ-025 Score SHALL never exceed MAX_SCORE, and lives SHALL never wrap below 0.
REQ-026 In IDLE, OVER_WIN and OVER_LOSE, match_pulse, miss_pulse and userquit SHALL be ignored.
REQ-027 In OVER_WIN and OVER_LOSE, score and lives SHALL remain frozen and visible on the outputs.
REQ-028 OVER_WIN/OVER_LOSE -> PLAY on a start edge, with a fresh clear and load as in REQ-018.
REQ-029 All outputs SHALL be registered or decoded only from registered state; latency from an input pulse to the visible output SHALL be 1 clock.
REQ-030 A start that is held high SHALL produce exactly one game start.

Reset
REQ-031 While reset is high: state = IDLE, score = 00, lives = LIVES, edge-detect history = 0.
REQ-032 Reset values of the outputs: ingameOn = 0, gameOver = 0, hex0hldr = 4'hF, hex4hldr = 0, hex5hldr = 0, ledrhldr = 10'h3FF (for LIVES = 10).
REQ-033 Reset asserted mid-game SHALL abort immediately, without waiting for a clock edge, to the REQ-031 values.

Verification
REQ-034 Reset, start edge, 9 match_pulses -> ingameOn = 1, hex5hldr = 0, hex4hldr = 9; one more match_pulse -> hex5hldr = 1, hex4hldr = 0.
REQ-035 Start, 32 match_pulses -> after the 32nd: hex5hldr = 3, hex4hldr = 2, hex0hldr = 4'hA, gameOver = 1; a further match_pulse leaves the score at 32.
REQ-036 Start, 10 miss_pulses -> ledrhldr steps 3FF, 1FF, ... 001, 000; hex0hldr = 4'hE; gameOver = 1.
REQ-037 Score 31 with lives 1, match_pulse and miss_pulse in the same cycle -> OVER_WIN, score 32, ledrhldr = 0.
REQ-038 In PLAY with score 05, userquit rises -> OVER_LOSE with score 05 held; userquit held high, then start edge -> PLAY with score 00 and ledrhldr = 3FF.
REQ-039 Start held high for 5 cycles, then reset pulsed mid-game -> exactly one start; on reset all outputs return to REQ-032 values asynchronously.
